// File: rtl/object_detect_pkg.sv
// Shared types and sizing for the object bounding-box extractor.
package object_detect_pkg;

    localparam int NUM_ROWS = 10;
    localparam int NUM_COLS = 10;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int CNT_W    = $clog2(NUM_ROWS * NUM_COLS + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    typedef enum logic {
        WAIT_TRAIN = 1'b0,
        ACCUM      = 1'b1
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0] min_row;
        logic [ROW_W-1:0] max_row;
        logic [COL_W-1:0] min_col;
        logic [COL_W-1:0] max_col;
        logic [CNT_W-1:0] fg_count;
        logic             found;
    } bbox_t;

    // Fold one foreground coordinate into a running box; the first hit seeds min=max.
    function automatic bbox_t bbox_merge(input bbox_t cur, input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
        bbox_t nxt;
        nxt = cur;
        if (!cur.found) begin
            nxt.min_row  = row;
            nxt.max_row  = row;
            nxt.min_col  = col;
            nxt.max_col  = col;
            nxt.fg_count = CNT_W'(1);
            nxt.found    = 1'b1;
        end else begin
            if (row < cur.min_row) nxt.min_row = row;
            if (row > cur.max_row) nxt.max_row = row;
            if (col < cur.min_col) nxt.min_col = col;
            if (col > cur.max_col) nxt.max_col = col;
            nxt.fg_count = cur.fg_count + CNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bbox_accumulator.sv
// Running bounding box for the frame in progress. o_next already includes the
// pixel presented this cycle so the caller can capture a complete frame result
// on the same edge that clears the accumulator.
module bbox_accumulator
    import object_detect_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    output bbox_t            o_next
);

    bbox_t acc_q;
    bbox_t acc_d;
    bbox_t merged;

    // Merge the current coordinate when it is foreground, then apply clear.
    always_comb begin
        merged = acc_q;
        if (i_update) merged = bbox_merge(acc_q, i_row, i_col);
        acc_d = i_clear ? '0 : merged;
    end

    // Accumulator register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign o_next = merged;

endmodule

// File: rtl/object_bbox_extractor.sv
// Reduces each raster frame from the detector to one bounding-box result and
// presents it on a valid/ready handshake with a sticky overrun flag.
module object_bbox_extractor
    import object_detect_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_img_data,
    input  logic             i_img_data_valid,
    input  logic             i_done_training,
    input  logic [7:0]       i_threshold,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [ROW_W-1:0] o_min_row,
    output logic [ROW_W-1:0] o_max_row,
    output logic [COL_W-1:0] o_min_col,
    output logic [COL_W-1:0] o_max_col,
    output logic [CNT_W-1:0] o_fg_count,
    output logic             o_object_found,
    output logic             o_overrun
);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       thr_q, thr_d;
    bbox_t            res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic             overrun_q, overrun_d;

    logic       pix_acc, first_pix, last_pix, drop, fg, acc_clear;
    logic [7:0] thr_eff;
    bbox_t      acc_next;

    bbox_accumulator u_acc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (acc_clear),
        .i_update (fg),
        .i_row    (row_q),
        .i_col    (col_q),
        .o_next   (acc_next)
    );

    // Next-state logic: FSM, raster counters, threshold latch and result handshake.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        thr_d       = thr_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;

        drop      = (state_q == ACCUM) && !i_done_training;
        pix_acc   = (state_q == ACCUM) && i_done_training && i_img_data_valid;
        first_pix = (row_q == '0) && (col_q == '0);
        // The first pixel of a frame is judged against the live threshold it latches.
        thr_eff   = first_pix ? i_threshold : thr_q;
        fg        = pix_acc && (i_img_data > thr_eff);
        last_pix  = pix_acc && (row_q == ROW_LAST) && (col_q == COL_LAST);
        acc_clear = last_pix || drop;

        case (state_q)
            WAIT_TRAIN: if (i_done_training) state_d = ACCUM;
            ACCUM:      if (!i_done_training) state_d = WAIT_TRAIN;
            default:    state_d = WAIT_TRAIN;
        endcase

        if (drop) begin
            row_d = '0;
            col_d = '0;
        end else if (pix_acc) begin
            if (first_pix) thr_d = i_threshold;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // A new result wins over an acceptance on the same edge; overrun only if it was not taken.
        if (last_pix) begin
            res_d       = acc_next;
            res_valid_d = 1'b1;
            if (res_valid_q && !i_result_ready) overrun_d = 1'b1;
        end else if (res_valid_q && i_result_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // All state registers, cleared by synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= WAIT_TRAIN;
            row_q       <= '0;
            col_q       <= '0;
            thr_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            thr_q       <= thr_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_result_valid = res_valid_q;
    assign o_min_row      = res_q.min_row;
    assign o_max_row      = res_q.max_row;
    assign o_min_col      = res_q.min_col;
    assign o_max_col      = res_q.max_col;
    assign o_fg_count     = res_q.fg_count;
    assign o_object_found = res_q.found;
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_object_bbox_extractor.sv
// Bench for object_bbox_extractor: table of frames with hand-derived bounding
// boxes, a result scoreboard, and hand sequences for reset, overrun and training.
module tb_object_bbox_extractor;
    import object_detect_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [7:0]       img_data;
    logic             img_valid;
    logic             done_training;
    logic [7:0]       threshold;
    logic             result_valid;
    logic             result_ready;
    logic [ROW_W-1:0] min_row, max_row;
    logic [COL_W-1:0] min_col, max_col;
    logic [CNT_W-1:0] fg_count;
    logic             object_found;
    logic             overrun;

    object_bbox_extractor dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_img_data       (img_data),
        .i_img_data_valid (img_valid),
        .i_done_training  (done_training),
        .i_threshold      (threshold),
        .o_result_valid   (result_valid),
        .i_result_ready   (result_ready),
        .o_min_row        (min_row),
        .o_max_row        (max_row),
        .o_min_col        (min_col),
        .o_max_col        (max_col),
        .o_fg_count       (fg_count),
        .o_object_found   (object_found),
        .o_overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixels with index lo..hi take value fg, the rest bg. thr is driven on pixel 0, thr_rest afterwards.
    typedef struct {
        int         lo;
        int         hi;
        logic [7:0] bg;
        logic [7:0] fg;
        logic [7:0] thr;
        logic [7:0] thr_rest;
        int         gap;
        int         e_min_row;
        int         e_max_row;
        int         e_min_col;
        int         e_max_col;
        int         e_cnt;
        int         e_found;
    } vec_t;

    typedef struct {
        int min_row;
        int max_row;
        int min_col;
        int max_col;
        int cnt;
        int found;
    } res_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    res_t exp_q [$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input vec_t v, input int i);
        return (i >= v.lo && i <= v.hi) ? v.fg : v.bg;
    endfunction

    function automatic res_t exp_of(input vec_t v);
        res_t r;
        r.min_row = v.e_min_row;
        r.max_row = v.e_max_row;
        r.min_col = v.e_min_col;
        r.max_col = v.e_max_col;
        r.cnt     = v.e_cnt;
        r.found   = v.e_found;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the last pixel edge.
    task automatic send_frame(input vec_t v, input bit chk_lat, input bit ready_last, input int npix);
        for (int i = 0; i < npix; i++) begin
            img_data  = pix(v, i);
            img_valid = 1'b1;
            threshold = (i == 0) ? v.thr : v.thr_rest;
            if (i == 99 && chk_lat) chk("valid_before_last", int'(result_valid), 0);
            if (i == 99 && ready_last) result_ready = 1'b1;
            @(posedge clk);
            #1;
            if (i == 99 && ready_last) result_ready = 1'b0;
            if (i == 99 && chk_lat) chk("valid_after_last", int'(result_valid), 1);
            img_valid = 1'b0;
            if (i < npix - 1) repeat (v.gap) begin
                @(posedge clk);
                #1;
            end
        end
        img_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain_queue_size", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_min_row"}, int'(min_row), 0);
        chk({tag, "_max_row"}, int'(max_row), 0);
        chk({tag, "_min_col"}, int'(min_col), 0);
        chk({tag, "_max_col"}, int'(max_col), 0);
        chk({tag, "_count"}, int'(fg_count), 0);
        chk({tag, "_found"}, int'(object_found), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Scoreboard: compare every accepted result against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got min_row=%0d count=%0d expected no result", min_row, fg_count);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("sb_min_row", int'(min_row), r.min_row);
                    chk("sb_max_row", int'(max_row), r.max_row);
                    chk("sb_min_col", int'(min_col), r.min_col);
                    chk("sb_max_col", int'(max_col), r.max_col);
                    chk("sb_count", int'(fg_count), r.cnt);
                    chk("sb_found", int'(object_found), r.found);
                end
            end
        end
    end

    initial begin
        vec_t only99, blank;
        //          lo  hi  bg   fg   thr  thr_r gap  minr maxr minc maxc cnt fnd
        vecs[0] = '{23, 23, 0,   200, 128, 128,  0,   2,   2,   3,   3,   1,  1};
        vecs[1] = '{-1, -2, 50,  0,   128, 128,  0,   0,   0,   0,   0,   0,  0};
        vecs[2] = '{0,  99, 255, 255, 128, 128,  5,   0,   9,   0,   9,   100, 1};
        vecs[3] = '{15, 34, 128, 129, 128, 128,  0,   1,   3,   0,   9,   20, 1};
        vecs[4] = '{99, 99, 0,   255, 128, 128,  1,   9,   9,   9,   9,   1,  1};
        vecs[5] = '{0,  99, 128, 128, 128, 128,  0,   0,   0,   0,   0,   0,  0};
        vecs[6] = '{50, 50, 0,   150, 100, 255,  0,   5,   5,   0,   0,   1,  1};
        vecs[7] = '{-1, -2, 10,  0,   255, 0,    0,   0,   0,   0,   0,   0,  0};
        vecs[8] = '{42, 44, 0,   1,   0,   0,    2,   4,   4,   2,   4,   3,  1};
        vecs[9] = '{0,  0,  0,   1,   0,   0,    0,   0,   0,   0,   0,   1,  1};
        only99 = vecs[4];
        only99.gap = 0;
        blank = '{0, 99, 255, 255, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst_n         = 1'b0;
        img_data      = '0;
        img_valid     = 1'b0;
        done_training = 1'b0;
        threshold     = '0;
        result_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Pixels before training completes must not advance the raster.
        send_frame(blank, 1'b0, 1'b0, 30);
        chk("pretrain_valid", int'(result_valid), 0);
        done_training = 1'b1;
        @(posedge clk);
        #1;

        mon_en       = 1'b1;
        result_ready = 1'b1;
        for (int v = 0; v < NVEC; v++) begin
            exp_q.push_back(exp_of(vecs[v]));
            send_frame(vecs[v], 1'b1, 1'b0, 100);
            drain();
        end

        // Overrun: two results with nobody accepting.
        mon_en       = 1'b0;
        result_ready = 1'b0;
        send_frame(vecs[0], 1'b1, 1'b0, 100);
        chk("ovr_first_overrun", int'(overrun), 0);
        send_frame(only99, 1'b0, 1'b0, 100);
        chk("ovr_valid", int'(result_valid), 1);
        chk("ovr_min_row", int'(min_row), 9);
        chk("ovr_min_col", int'(min_col), 9);
        chk("ovr_count", int'(fg_count), 1);
        chk("ovr_overrun", int'(overrun), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_stable_valid", int'(result_valid), 1);
        chk("ovr_stable_max_col", int'(max_col), 9);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("ovr_valid_dropped", int'(result_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset mid-frame with a result pending discards everything.
        send_frame(vecs[0], 1'b0, 1'b0, 100);
        send_frame(vecs[2], 1'b0, 1'b0, 37);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("midreset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Acceptance on the load edge: new result stays valid, no overrun.
        send_frame(vecs[0], 1'b1, 1'b0, 100);
        send_frame(only99, 1'b0, 1'b1, 100);
        chk("same_edge_valid", int'(result_valid), 1);
        chk("same_edge_max_row", int'(max_row), 9);
        chk("same_edge_overrun", int'(overrun), 0);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("same_edge_accept", int'(result_valid), 0);

        // Full frame after the mid-frame reset is reported through the scoreboard.
        mon_en = 1'b1;
        exp_q.push_back(exp_of(vecs[0]));
        send_frame(vecs[0], 1'b1, 1'b0, 100);
        drain();

        // Dropping training mid-frame discards the partial frame.
        send_frame(blank, 1'b0, 1'b0, 40);
        done_training = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        done_training = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_of(only99));
        send_frame(only99, 1'b1, 1'b0, 100);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
